region_jump_tracer: RTL and testbench

REGION_JUMP_TRACER -- requirements
Module: region_jump_tracer

---
 rtl/region_jump_tracer.sv | 163 ++++++++++++++++
 tb/tb_region_jump_tracer.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/region_jump_tracer.sv
// Logs transitions of retired pc between tagged memory regions into a trace FIFO.
// Optional macro TRACER_TIMESTAMP_EN adds a 16-bit cycle stamp to each entry.
module region_jump_tracer #(
    parameter int NUM_REGIONS = 2,
    parameter logic [4*NUM_REGIONS-1:0] REGION_TAGS = 8'h14,
    parameter int RESET_REGION = 0,
    parameter int DEPTH = 16,
    parameter int TIMEOUT = 1000,
    localparam int RID_W = $clog2(NUM_REGIONS+1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             pc_valid,
    input  logic [31:0]      pc,
    output logic             trace_valid,
    input  logic             trace_ready,
    output logic [RID_W-1:0] trace_from,
    output logic [RID_W-1:0] trace_to,
    output logic [31:0]      trace_pc,
    output logic [15:0]      trace_cycle,
    output logic [RID_W-1:0] cur_region,
    output logic             overflow,
    output logic             illegal,
    output logic             stall,
    output logic [7:0]       drop_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int WD_W  = $clog2(TIMEOUT+1);

    logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [RID_W-1:0] cur_q, cur_d, rid;
    logic             ovf_q, ovf_d, ill_q, ill_d, stall_q, stall_d;
    logic [7:0]       drop_q, drop_d;
    logic [WD_W-1:0]  wd_q, wd_d;
    logic             empty, full, pop, push, wr_en, drop;

    logic [RID_W-1:0] from_mem [DEPTH];
    logic [RID_W-1:0] to_mem   [DEPTH];
    logic [31:0]      pc_mem   [DEPTH];

    // Descending scan so the lowest matching region wins.
    always_comb begin
        rid = RID_W'(NUM_REGIONS);
        for (int k = NUM_REGIONS-1; k >= 0; k--) begin
            if (REGION_TAGS[4*k +: 4] == pc[31:28]) rid = RID_W'(k);
        end
    end

    assign empty = (cnt_q == '0);
    assign full  = (cnt_q == CNT_W'(DEPTH));
    assign pop   = !empty && trace_ready && !clear;
    assign push  = pc_valid && (rid != cur_q) && !clear;
    assign wr_en = push && (!full || pop);
    assign drop  = push && full && !pop;

    always_comb begin
        wr_d    = wr_q;
        rd_d    = rd_q;
        cnt_d   = cnt_q;
        cur_d   = cur_q;
        ovf_d   = ovf_q;
        ill_d   = ill_q;
        stall_d = stall_q;
        drop_d  = drop_q;
        wd_d    = wd_q;
        if (clear) begin
            wr_d    = '0;
            rd_d    = '0;
            cnt_d   = '0;
            cur_d   = RID_W'(RESET_REGION);
            ovf_d   = 1'b0;
            ill_d   = 1'b0;
            stall_d = 1'b0;
            drop_d  = '0;
            wd_d    = '0;
        end else begin
            if (wr_en) wr_d = wr_q + PTR_W'(1);
            if (pop)   rd_d = rd_q + PTR_W'(1);
            unique case ({wr_en, pop})
                2'b10:   cnt_d = cnt_q + CNT_W'(1);
                2'b01:   cnt_d = cnt_q - CNT_W'(1);
                default: cnt_d = cnt_q;
            endcase
            if (drop) begin
                ovf_d = 1'b1;
                if (drop_q != 8'hFF) drop_d = drop_q + 8'd1;
            end
            if (push) begin
                cur_d = rid;
                if (rid == RID_W'(NUM_REGIONS)) ill_d = 1'b1;
            end
            if (pc_valid)                     wd_d = '0;
            else if (wd_q != WD_W'(TIMEOUT))  wd_d = wd_q + WD_W'(1);
            if (wd_d == WD_W'(TIMEOUT))       stall_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
            cur_q   <= RID_W'(RESET_REGION);
            ovf_q   <= 1'b0;
            ill_q   <= 1'b0;
            stall_q <= 1'b0;
            drop_q  <= '0;
            wd_q    <= '0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            cnt_q   <= cnt_d;
            cur_q   <= cur_d;
            ovf_q   <= ovf_d;
            ill_q   <= ill_d;
            stall_q <= stall_d;
            drop_q  <= drop_d;
            wd_q    <= wd_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            from_mem[wr_q] <= cur_q;
            to_mem[wr_q]   <= rid;
            pc_mem[wr_q]   <= pc;
        end
    end

`ifdef TRACER_TIMESTAMP_EN
    logic [15:0] ts_q;
    logic [15:0] ts_mem [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     ts_q <= '0;
        else if (clear) ts_q <= '0;
        else            ts_q <= ts_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (wr_en) ts_mem[wr_q] <= ts_q;
    end

    assign trace_cycle = trace_valid ? ts_mem[rd_q] : '0;
`else
    assign trace_cycle = '0;
`endif

    assign trace_valid = !empty;
    assign trace_from  = trace_valid ? from_mem[rd_q] : '0;
    assign trace_to    = trace_valid ? to_mem[rd_q]   : '0;
    assign trace_pc    = trace_valid ? pc_mem[rd_q]   : '0;
    assign cur_region  = cur_q;
    assign overflow    = ovf_q;
    assign illegal     = ill_q;
    assign stall       = stall_q;
    assign drop_count  = drop_q;

endmodule

// File: tb/tb_region_jump_tracer.sv
// Directed and random checks of region_jump_tracer against a queue-based model.
// Expectations follow TRACER_TIMESTAMP_EN when it is defined for the build.
module tb_region_jump_tracer;

    localparam int NR = 2;
    localparam logic [7:0] TAGS = 8'h14;
    localparam int DEPTH = 4;
    localparam int TIMEOUT = 10;

    typedef struct {
        int          from;
        int          to;
        logic [31:0] pc;
        int          ts;
    } entry_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clear = 1'b0;
    logic        pc_valid = 1'b0;
    logic [31:0] pc = '0;
    logic        trace_ready = 1'b0;
    logic        trace_valid;
    logic [1:0]  trace_from, trace_to, cur_region;
    logic [31:0] trace_pc;
    logic [15:0] trace_cycle;
    logic        overflow, illegal, stall;
    logic [7:0]  drop_count;

    region_jump_tracer #(
        .NUM_REGIONS(NR), .REGION_TAGS(TAGS), .RESET_REGION(0),
        .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .pc_valid(pc_valid), .pc(pc),
        .trace_valid(trace_valid), .trace_ready(trace_ready),
        .trace_from(trace_from), .trace_to(trace_to),
        .trace_pc(trace_pc), .trace_cycle(trace_cycle),
        .cur_region(cur_region), .overflow(overflow),
        .illegal(illegal), .stall(stall), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail = 0;

    entry_t q[$];
    int m_cur, m_drops, m_idle, m_ts;
    bit m_ovf, m_ill, m_stall;

    function automatic int region_of(logic [31:0] p);
        for (int k = 0; k < NR; k++)
            if (TAGS[4*k +: 4] == p[31:28]) return k;
        return NR;
    endfunction

    task automatic model_reset();
        q.delete();
        m_cur = 0; m_drops = 0; m_idle = 0; m_ts = 0;
        m_ovf = 0; m_ill = 0; m_stall = 0;
    endtask

    task automatic model_step(bit pv, logic [31:0] p, bit rdy, bit clr);
        int r;
        bit pop, push;
        entry_t e;
        if (clr) begin
            model_reset();
            return;
        end
        r = region_of(p);
        pop = (q.size() > 0) && rdy;
        push = pv && (r != m_cur);
        if (push) begin
            e.from = m_cur; e.to = r; e.pc = p; e.ts = m_ts;
        end
        if (pop) void'(q.pop_front());
        if (push) begin
            if (q.size() < DEPTH) q.push_back(e);
            else begin
                m_ovf = 1;
                if (m_drops < 255) m_drops++;
            end
            if (r == NR) m_ill = 1;
            m_cur = r;
        end
        if (pv) m_idle = 0;
        else if (m_idle < TIMEOUT) m_idle++;
        if (m_idle == TIMEOUT) m_stall = 1;
        m_ts = (m_ts + 1) % 65536;
    endtask

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        entry_t e;
        e.from = 0; e.to = 0; e.pc = '0; e.ts = 0;
        if (q.size() > 0) e = q[0];
`ifndef TRACER_TIMESTAMP_EN
        e.ts = 0;
`endif
        chk("trace_valid", 64'(trace_valid), 64'(q.size() > 0));
        chk("trace_from", 64'(trace_from), 64'(e.from));
        chk("trace_to", 64'(trace_to), 64'(e.to));
        chk("trace_pc", 64'(trace_pc), 64'(e.pc));
        chk("trace_cycle", 64'(trace_cycle), 64'(e.ts));
        chk("cur_region", 64'(cur_region), 64'(m_cur));
        chk("overflow", 64'(overflow), 64'(m_ovf));
        chk("illegal", 64'(illegal), 64'(m_ill));
        chk("stall", 64'(stall), 64'(m_stall));
        chk("drop_count", 64'(drop_count), 64'(m_drops));
    endtask

    task automatic drive_step(bit pv, logic [31:0] p, bit rdy, bit clr);
        pc_valid = pv; pc = p; trace_ready = rdy; clear = clr;
        model_step(pv, p, rdy, clr);
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic cyc(bit pv, logic [31:0] p, bit rdy, bit clr);
        @(negedge clk);
        drive_step(pv, p, rdy, clr);
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
        drive_step(0, '0, 0, 0);
    endtask

    logic [31:0] rp;
    int exp_ts;

    initial begin
        model_reset();
        #2;
        check_all();
        release_reset();

        // first jump BIOS -> IMEM
        cyc(1, 32'h4000_0000, 0, 0);
        chk("no_push_same_region", 64'(trace_valid), 64'd0);
        cyc(1, 32'h1000_0000, 0, 0);
        chk("first_to", 64'(trace_to), 64'd1);
        chk("first_pc", 64'(trace_pc), 64'h1000_0000);
        chk("first_cur", 64'(cur_region), 64'd1);

        // return to BIOS while popping the first entry
        cyc(1, 32'h4000_0008, 1, 0);
        chk("second_from", 64'(trace_from), 64'd1);
        chk("second_to", 64'(trace_to), 64'd0);
        chk("second_pc", 64'(trace_pc), 64'h4000_0008);
        cyc(0, '0, 1, 0);

        // overflow with consumer stalled
        cyc(0, '0, 0, 1);
        for (int i = 0; i < 6; i++)
            cyc(1, (i % 2 == 0) ? 32'h1000_0000 : 32'h4000_0000, 0, 0);
        chk("ovf_flag", 64'(overflow), 64'd1);
        chk("ovf_drops", 64'(drop_count), 64'd2);
        cyc(1, 32'h1000_0004, 1, 0);
        chk("full_push_pop_drops", 64'(drop_count), 64'd2);
        for (int i = 0; i < 4; i++) cyc(0, '0, 1, 0);

        // illegal region
        cyc(1, 32'h8000_0000, 0, 0);
        chk("illegal_to", 64'(trace_to), 64'd2);
        chk("illegal_flag", 64'(illegal), 64'd1);

        // watchdog, then clear with a simultaneous pc_valid
        cyc(0, '0, 0, 1);
        for (int i = 0; i < TIMEOUT - 1; i++) cyc(0, '0, 0, 0);
        chk("stall_before", 64'(stall), 64'd0);
        cyc(0, '0, 0, 0);
        chk("stall_at_limit", 64'(stall), 64'd1);
        cyc(1, 32'h1000_0000, 0, 1);
        chk("clear_stall", 64'(stall), 64'd0);
        chk("clear_valid", 64'(trace_valid), 64'd0);
        chk("clear_cur", 64'(cur_region), 64'd0);

        // timestamp of a jump five cycles after clear
        for (int i = 0; i < 4; i++) cyc(0, '0, 0, 0);
        cyc(1, 32'h4000_0000, 0, 0);
        cyc(1, 32'h1000_0000, 0, 0);
`ifdef TRACER_TIMESTAMP_EN
        exp_ts = 5;
`else
        exp_ts = 0;
`endif
        chk("timestamp", 64'(trace_cycle), 64'(exp_ts));

        // asynchronous reset with entries pending
        cyc(1, 32'h4000_0000, 0, 0);
        rst_n = 1'b0;
        pc_valid = 1'b0; trace_ready = 1'b0; clear = 1'b0;
        #1;
        model_reset();
        check_all();
        release_reset();

        // random traffic
        for (int i = 0; i < 400; i++) begin
            rp = $urandom;
            case ($urandom_range(0, 3))
                0: rp[31:28] = 4'h4;
                1: rp[31:28] = 4'h1;
                2: rp[31:28] = 4'h8;
                default: ;
            endcase
            cyc($urandom_range(0, 2) == 0, rp, $urandom_range(0, 1) == 1,
                $urandom_range(0, 63) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
